shift_sequence_ctrl: RTL
========================

# shift_sequence_ctrl

Multi-cycle sequencer that performs a shift of any 8-bit amount (0–255) on a 16-bit mantissa using a single instance of the 16-bit universal barrel shifter. The shifter moves at most 15 positions per pass, so the controller issues one pass per clock until the requested amount is consumed. It sits between the floating-point align/normalise logic and the shifter, behind a start/done handshake.

## Interface
Parameters:
- MAX_STEP, 15: largest per-pass amount driven on the shifter's 4-bit shift port. Legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request pulse. Sampled only while idle.
- dir  in  1  shift-choice value: 0 shifts left, 1 shifts right. Driven straight to the shifter's choice input.
- mant_in  in  16  operand.
- shamt_in  in  8  total shift amount.
- busy  out  1  high from the accepting edge until done drops.
- done  out  1  one-cycle pulse; result is valid while done is high.
- result  out  16  shifted value. Held after done until the next accepted start.
- sticky  out  1  OR of all 1-bits shifted out on a right shift. Function depends on STICKY_EN.

## Operation
- Internal registers:
  - data[16], rem[8], dir_r, sticky_r.
  - FSM states IDLE, SHIFT, DONE.
- IDLE:
  - start=1 latches mant_in→data, shamt_in→rem, dir→dir_r, and clears sticky_r.
  - If shamt_in==0 the next state is DONE. Otherwise it is SHIFT.
- SHIFT: each cycle, step = min(rem, MAX_STEP).
  - The shifter is driven with data, step and dir_r.
  - On the edge: data←shifter out and rem←rem−step.
  - If rem−step==0 the next state is DONE; otherwise the FSM stays in SHIFT.
  - Vacated bits are zero-filled.
- DONE: done=1 for one cycle. The next state is IDLE unconditionally.
- start while busy is ignored. It is not queued.
- result is driven from data. mant_in, dir and shamt_in are don't-care after the accepting edge.
- The width of rem is never exceeded, because step ≤ rem always.

## Timing
- Reset (asynchronous, at any time, including mid-SHIFT):
  - FSM→IDLE.
  - busy=0, done=0, result=16'h0000, sticky=0, rem=0.
  - Any in-flight operation is discarded.
- Let k = ceil(shamt_in/MAX_STEP), with edge T0 being the edge that accepts start:
  - done is high in the cycle after edge Tk.
  - For shamt_in=0, done is high in the cycle after T0.
  - Latency from start to done is k+1 cycles. The worst case with shamt_in=255 and MAX_STEP=15 is 18 cycles.
- busy goes high after T0 and falls together with done when the FSM returns to IDLE.
- The earliest next accepted start is the edge that leaves DONE, so back-to-back throughput is one operation per k+2 cycles.

## Configuration
- STICKY_EN defined:
  - On each SHIFT cycle with dir_r=1: sticky_r |= |(data & ((1<<step)−1)).
  - Left shifts never set sticky_r.
  - sticky = sticky_r. It is valid with done and held with result.
- STICKY_EN undefined:
  - No mask or accumulation logic is built.
  - sticky is tied to 0.

## Test plan
- Reset mid-operation: accept shamt=200 and pull rst_n low after 5 cycles.
  - Required: busy, done, result and sticky are 0 immediately (asynchronously).
  - Required: a new start after release completes normally.
- Left 3: start with mant_in=16'hB252, dir=0, shamt=3.
  - Required: done 2 cycles later with result=16'h9290 and sticky=0.
- Right 3 and zero shift:
  - Start with 16'hB252, dir=1, shamt=3. Required: result=16'h164A. With STICKY_EN, sticky=1 (the lost bits are 010); without it, sticky=0.
  - Start with shamt=0. Required: done in the next cycle and result=mant_in.
- Multi-pass right: start with 16'hB252, dir=1, shamt=20 (passes of 15 and 5).
  - Required: done 3 cycles after start, result=16'h0000, and sticky=1 with STICKY_EN.
- Exact step boundary and maximum:
  - Start with 16'h8000, dir=1, shamt=15. Required: one pass, result=16'h0001, sticky=0.
  - Start with shamt=255. Required: done exactly 18 cycles after start and result=0.
- Busy rejection: assert start with new operands every cycle during an operation.
  - Required: the result reflects only the first operands.
  - Required: no extra done pulses, and busy stays continuous until done.

Source files
------------

// File: rtl/shift_sequence_ctrl_if.sv
// shift_sequence_ctrl_if
// Start/done handshake and operand/result bundle between the floating-point
// align/normalise logic (master) and the multi-pass shift sequencer (slave).
//
// Signals:
//   start     master->slave  request pulse, sampled only while the sequencer idles
//   dir       master->slave  0 shifts left, 1 shifts right
//   mant_in   master->slave  16-bit operand
//   shamt_in  master->slave  8-bit total shift amount (0..255)
//   busy      slave->master  operation in flight
//   done      slave->master  one-cycle pulse, result valid while high
//   result    slave->master  shifted value, held until the next accepted start
//   sticky    slave->master  OR of bits lost on a right shift (0 unless STICKY_EN)
interface shift_sequence_ctrl_if;
  logic        start;
  logic        dir;
  logic [15:0] mant_in;
  logic [7:0]  shamt_in;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        sticky;

  modport master (
    output start, dir, mant_in, shamt_in,
    input  busy, done, result, sticky
  );

  modport slave (
    input  start, dir, mant_in, shamt_in,
    output busy, done, result, sticky
  );
endinterface

// File: rtl/shift_sequence_ctrl.sv
// shift_sequence_ctrl
// Performs a shift of any 8-bit amount on a 16-bit mantissa with a single
// 16-bit barrel shifter that moves at most MAX_STEP positions per pass. One
// pass is issued per clock until the requested amount has been consumed.
//
// Parameters:
//   MAX_STEP  largest per-pass amount on the shifter's 4-bit port (1..15)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    shift_sequence_ctrl_if.slave (start/dir/mant_in/shamt_in in,
//          busy/done/result/sticky out)
//
// Optional feature macro:
//   STICKY_EN  when defined, sticky accumulates every 1-bit shifted out on a
//              right shift; when undefined, sticky is tied to 0 and no mask
//              or accumulation logic exists.
module shift_sequence_ctrl #(
  parameter int MAX_STEP = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shift_sequence_ctrl_if.slave bus
);

  localparam logic [7:0] MAX_STEP_W = 8'(MAX_STEP);
  localparam logic [3:0] MAX_STEP_4 = 4'(MAX_STEP);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] data;
  logic [7:0]  rem;
  logic        dir_r;
  logic [3:0]  step;
  logic [7:0]  rem_after;
  logic [15:0] shift_out;
  logic        accept;

  // Per-pass amount is the smaller of what is left and what the shifter can
  // move in one go; since step never exceeds rem the subtraction cannot wrap.
  always_comb begin
    step      = (rem < MAX_STEP_W) ? rem[3:0] : MAX_STEP_4;
    rem_after = rem - {4'b0000, step};
  end

  // The single barrel shifter, zero-filling vacated positions in both
  // directions and steered by the direction captured at acceptance.
  always_comb begin
    if (dir_r) begin
      shift_out = data >> step;
    end else begin
      shift_out = data << step;
    end
  end

  // State register; an asynchronous reset throws away any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs. A zero amount skips straight to DONE so
  // the operand comes back unchanged one cycle after acceptance. start is only
  // looked at in IDLE, so requests made while busy simply vanish.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = (bus.shamt_in == 8'd0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        bus.busy = 1'b1;
        if (rem_after == 8'd0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        bus.busy  = 1'b1;
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture on acceptance, then one shifter pass per SHIFT cycle.
  // data doubles as the result register, so it stays put after done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= 16'h0000;
      rem   <= 8'd0;
      dir_r <= 1'b0;
    end else if (accept) begin
      data  <= bus.mant_in;
      rem   <= bus.shamt_in;
      dir_r <= bus.dir;
    end else if (state == SHIFT) begin
      data <= shift_out;
      rem  <= rem_after;
    end
  end

  assign bus.result = data;

`ifdef STICKY_EN
  logic        sticky_r;
  logic [15:0] lost_mask;

  // Mask of the low bits about to fall off the right end this pass.
  always_comb begin
    lost_mask = (16'h0001 << step) - 16'h0001;
  end

  // Sticky is cleared on acceptance and only ever gathers bits on right
  // shifts; it is held alongside the result afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_r <= 1'b0;
    end else if (accept) begin
      sticky_r <= 1'b0;
    end else if ((state == SHIFT) && dir_r) begin
      sticky_r <= sticky_r | (|(data & lost_mask));
    end
  end

  assign bus.sticky = sticky_r;
`else
  assign bus.sticky = 1'b0;
`endif

endmodule
